// File: rtl/bp_be_dcache_pkt_decoder_pkg.sv
// Shared types for the dcache packet decoder.
//   - bp_be_dcache_opcode_e      : 4-bit dcache opcode {store, unsigned, log2(size)}
//   - bp_be_dcache_decode_s      : decoded opcode fields
//   - bp_be_dcache_load_track_s  : per-load bookkeeping kept until read data returns
//   - size_mask_f                : byte-lane mask for an access size, lane 0 based
package bp_be_dcache_pkt_decoder_pkg;

    localparam int dword_width_gp = 64;

    typedef enum logic [3:0] {
        e_dcache_op_lb  = 4'b0000,
        e_dcache_op_lh  = 4'b0001,
        e_dcache_op_lw  = 4'b0010,
        e_dcache_op_ld  = 4'b0011,
        e_dcache_op_lbu = 4'b0100,
        e_dcache_op_lhu = 4'b0101,
        e_dcache_op_lwu = 4'b0110,
        e_dcache_op_sb  = 4'b1000,
        e_dcache_op_sh  = 4'b1001,
        e_dcache_op_sw  = 4'b1010,
        e_dcache_op_sd  = 4'b1011
    } bp_be_dcache_opcode_e;

    typedef struct packed {
        logic       store;
        logic       is_unsigned;
        logic [1:0] size;
    } bp_be_dcache_decode_s;

    typedef struct packed {
        bp_be_dcache_decode_s decode;
        logic [2:0]           offset;
    } bp_be_dcache_load_track_s;

    // One bit per byte covered by an access of 2**size bytes, starting at lane 0.
    function automatic logic [7:0] size_mask_f(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO, ready-then-valid on the input side.
//   clk_i, reset_i : clock, synchronous active-high reset
//   v_i, ready_o   : enqueue request / space available (from registered count only)
//   data_i         : enqueue payload
//   v_o, data_o    : head valid / head payload
//   yumi_i         : consume head (ignored when v_o is low)
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_wptr;
    logic [ptr_w_lp-1:0] r_rptr;
    logic [cnt_w_lp-1:0] r_count;

    logic w_enq;
    logic w_deq;

    function automatic logic [ptr_w_lp-1:0] ptr_inc_f(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (r_count != cnt_w_lp'(els_p));
    assign v_o     = (r_count != '0);
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;
    assign data_o  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= ptr_inc_f(r_wptr);
            if (w_deq) r_rptr <= ptr_inc_f(r_rptr);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: occupancy is tracked solely by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/bp_be_dcache_pkt_decoder.sv
// MMU-to-dcache packet receiver.
// Decodes packets into lane-aligned array requests (address, store flag, byte
// write mask, shifted write data), tracks outstanding loads in order and turns
// returning 64-bit array words into sign/zero-extended load results.
//   pkt_*          : incoming packet, accepted on pkt_v_i & pkt_ready_o
//   req_*          : array request head, popped on req_yumi_i
//   rdata_v_i/_i   : read data for the oldest outstanding load
//   load_v_o/_data : registered, extended load result (one-cycle valid)
//   misaligned_v_o, illegal_v_o : one-cycle error pulses, cycle after acceptance
module bp_be_dcache_pkt_decoder
    import bp_be_dcache_pkt_decoder_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int data_width_p  = 64,
    parameter int els_p         = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     pkt_v_i,
    input  logic [3:0]               pkt_opcode_i,
    input  logic [vaddr_width_p-1:0] pkt_addr_i,
    input  logic [data_width_p-1:0]  pkt_data_i,
    output logic                     pkt_ready_o,
    output logic                     req_v_o,
    input  logic                     req_yumi_i,
    output logic [vaddr_width_p-1:0] req_addr_o,
    output logic                     req_store_o,
    output logic [7:0]               req_wmask_o,
    output logic [data_width_p-1:0]  req_wdata_o,
    input  logic                     rdata_v_i,
    input  logic [data_width_p-1:0]  rdata_i,
    output logic                     load_v_o,
    output logic [data_width_p-1:0]  load_data_o,
    output logic                     misaligned_v_o,
    output logic                     illegal_v_o
);

    typedef struct packed {
        logic [vaddr_width_p-1:0] addr;
        logic                     store;
        logic [7:0]               wmask;
        logic [data_width_p-1:0]  wdata;
    } req_entry_s;

    // ---------------- packet decode ----------------
    bp_be_dcache_decode_s w_decode;
    logic [2:0]           w_offset;
    logic                 w_illegal;
    logic                 w_misaligned;
    logic [7:0]           w_size_mask;
    logic [data_width_p-1:0] w_data_masked;
    logic                 w_accept;
    logic                 w_req_enq;
    logic                 w_trk_enq;

    assign w_decode.store       = pkt_opcode_i[3];
    assign w_decode.is_unsigned = pkt_opcode_i[2];
    assign w_decode.size        = pkt_opcode_i[1:0];
    assign w_offset             = pkt_addr_i[2:0];

    // 4'b11xx is exactly "store with the unsigned bit set".
    assign w_illegal = (pkt_opcode_i == 4'b0111) | (pkt_opcode_i[3] & pkt_opcode_i[2]);

    always_comb begin
        w_misaligned = 1'b0;
        case (w_decode.size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = w_offset[0];
            2'd2:    w_misaligned = |w_offset[1:0];
            default: w_misaligned = |w_offset;
        endcase
    end

    assign w_size_mask = size_mask_f(w_decode.size);

    // Zero every byte above the access size before shifting into its lanes.
    for (genvar gi = 0; gi < 8; gi++) begin : g_data_mask
        assign w_data_masked[8*gi +: 8] = w_size_mask[gi] ? pkt_data_i[8*gi +: 8] : 8'h00;
    end

    assign w_accept  = pkt_v_i & pkt_ready_o;
    assign w_req_enq = w_accept & ~w_illegal & ~w_misaligned;
    assign w_trk_enq = w_req_enq & ~w_decode.store;

    req_entry_s w_req_in;
    assign w_req_in.addr  = {pkt_addr_i[vaddr_width_p-1:3], 3'b000};
    assign w_req_in.store = w_decode.store;
    assign w_req_in.wmask = w_decode.store ? (w_size_mask << w_offset) : 8'h00;
    assign w_req_in.wdata = w_data_masked << {w_offset, 3'b000};

    // ---------------- request FIFO ----------------
    logic       w_req_ready;
    req_entry_s w_req_head;

    bsg_fifo_1r1w_small #(
        .width_p ($bits(req_entry_s)),
        .els_p   (els_p)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_req_enq),
        .ready_o (w_req_ready),
        .data_i  (w_req_in),
        .v_o     (req_v_o),
        .data_o  (w_req_head),
        .yumi_i  (req_yumi_i)
    );

    assign req_addr_o  = w_req_head.addr;
    assign req_store_o = w_req_head.store;
    assign req_wmask_o = w_req_head.wmask;
    assign req_wdata_o = w_req_head.wdata;

    // ---------------- load-tracking FIFO ----------------
    logic                     w_trk_ready;
    logic                     w_trk_v;
    logic                     w_trk_pop;
    bp_be_dcache_load_track_s w_trk_in;
    bp_be_dcache_load_track_s w_trk_head;

    assign w_trk_in.decode = w_decode;
    assign w_trk_in.offset = w_offset;
    assign w_trk_pop       = rdata_v_i & w_trk_v;

    bsg_fifo_1r1w_small #(
        .width_p ($bits(bp_be_dcache_load_track_s)),
        .els_p   (els_p)
    ) u_trk_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_trk_enq),
        .ready_o (w_trk_ready),
        .data_i  (w_trk_in),
        .v_o     (w_trk_v),
        .data_o  (w_trk_head),
        .yumi_i  (w_trk_pop)
    );

    // Both FIFO ready signals come from registered counts, so a dequeue in
    // this cycle cannot open a slot until the next one.
    assign pkt_ready_o = w_req_ready & w_trk_ready;

    // ---------------- load data extraction ----------------
    logic [data_width_p-1:0] w_shifted;
    logic [data_width_p-1:0] w_load_ext;
    logic                    w_sext;

    assign w_shifted = rdata_i >> {w_trk_head.offset, 3'b000};
    assign w_sext    = ~w_trk_head.decode.is_unsigned;

    always_comb begin
        w_load_ext = w_shifted;
        case (w_trk_head.decode.size)
            2'd0: w_load_ext = {{(data_width_p-8){w_sext & w_shifted[7]}}, w_shifted[7:0]};
            2'd1: w_load_ext = {{(data_width_p-16){w_sext & w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_load_ext = {{(data_width_p-32){w_sext & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    // ---------------- registered outputs ----------------
    logic                    r_load_v;
    logic [data_width_p-1:0] r_load_data;
    logic                    r_misaligned;
    logic                    r_illegal;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_load_v     <= 1'b0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            // Tracked entries are always loads; the store bit only guards against
            // a corrupted entry ever producing a response.
            r_load_v     <= w_trk_pop & ~w_trk_head.decode.store;
            if (w_trk_pop) r_load_data <= w_load_ext;
            r_illegal    <= w_accept & w_illegal;
            r_misaligned <= w_accept & ~w_illegal & w_misaligned;
        end
    end

    assign load_v_o       = r_load_v;
    assign load_data_o    = r_load_data;
    assign misaligned_v_o = r_misaligned;
    assign illegal_v_o    = r_illegal;

    // Read data with nothing outstanding is dropped above; flag it in simulation.
    a_rdata_has_load: assert property (@(posedge clk_i) disable iff (reset_i)
        !(rdata_v_i && !w_trk_v));
    a_yumi_has_req: assert property (@(posedge clk_i) disable iff (reset_i)
        !(req_yumi_i && !req_v_o));

endmodule

// File: tb/tb_bp_be_dcache_pkt_decoder.sv
module tb_bp_be_dcache_pkt_decoder;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        pkt_v_i;
    logic [3:0]  pkt_opcode_i;
    logic [38:0] pkt_addr_i;
    logic [63:0] pkt_data_i;
    logic        pkt_ready_o;
    logic        req_v_o;
    logic        req_yumi_i;
    logic [38:0] req_addr_o;
    logic        req_store_o;
    logic [7:0]  req_wmask_o;
    logic [63:0] req_wdata_o;
    logic        rdata_v_i;
    logic [63:0] rdata_i;
    logic        load_v_o;
    logic [63:0] load_data_o;
    logic        misaligned_v_o;
    logic        illegal_v_o;

    int total = 0;
    int bad   = 0;

    bp_be_dcache_pkt_decoder #(
        .vaddr_width_p (39),
        .data_width_p  (64),
        .els_p         (2)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .pkt_v_i        (pkt_v_i),
        .pkt_opcode_i   (pkt_opcode_i),
        .pkt_addr_i     (pkt_addr_i),
        .pkt_data_i     (pkt_data_i),
        .pkt_ready_o    (pkt_ready_o),
        .req_v_o        (req_v_o),
        .req_yumi_i     (req_yumi_i),
        .req_addr_o     (req_addr_o),
        .req_store_o    (req_store_o),
        .req_wmask_o    (req_wmask_o),
        .req_wdata_o    (req_wdata_o),
        .rdata_v_i      (rdata_v_i),
        .rdata_i        (rdata_i),
        .load_v_o       (load_v_o),
        .load_data_o    (load_data_o),
        .misaligned_v_o (misaligned_v_o),
        .illegal_v_o    (illegal_v_o)
    );

    always #5 clk = ~clk;

    // kind: 0 = legal request, 1 = misaligned, 2 = illegal
    typedef struct {
        logic [3:0]  op;
        logic [38:0] addr;
        logic [63:0] data;
        logic [63:0] rdata;
        int          kind;
        logic        st;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] ldata;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic [38:0] addr,
                                input logic [63:0] data, input logic [63:0] rdata,
                                input int kind, input logic st, input logic [7:0] wmask,
                                input logic [63:0] wdata, input logic [63:0] ldata);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.rdata = rdata; v.kind = kind;
        v.st = st; v.wmask = wmask; v.wdata = wdata; v.ldata = ldata;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [38:0] addr, input logic [63:0] data);
        pkt_v_i = 1'b1; pkt_opcode_i = op; pkt_addr_i = addr; pkt_data_i = data;
    endtask

    vec_t vecs[22];

    initial begin
        vecs[0]  = mk(4'b0000, 39'h1003, 64'h0, 64'h1122_3344_80AA_BBCC, 0, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[1]  = mk(4'b0100, 39'h1003, 64'h0, 64'h1122_3344_80AA_BBCC, 0, 0, 8'h00, 64'h0, 64'h0000_0000_0000_0080);
        vecs[2]  = mk(4'b1010, 39'h2004, 64'hDEAD_1122_3344, 64'h0, 0, 1, 8'hF0, 64'h1122_3344_0000_0000, 64'h0);
        vecs[3]  = mk(4'b0001, 39'h1001, 64'h0, 64'h0, 1, 0, 8'h00, 64'h0, 64'h0);
        vecs[4]  = mk(4'b0111, 39'h1000, 64'h0, 64'h0, 2, 0, 8'h00, 64'h0, 64'h0);
        vecs[5]  = mk(4'b1000, 39'h0007, 64'hFFFF_FFA5, 64'h0, 0, 1, 8'h80, 64'hA500_0000_0000_0000, 64'h0);
        vecs[6]  = mk(4'b1001, 39'h0006, 64'h1234_5678, 64'h0, 0, 1, 8'hC0, 64'h5678_0000_0000_0000, 64'h0);
        vecs[7]  = mk(4'b1011, 39'h0018, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
        vecs[8]  = mk(4'b0010, 39'h0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321);
        vecs[9]  = mk(4'b0110, 39'h0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 8'h00, 64'h0, 64'h0000_0000_8765_4321);
        vecs[10] = mk(4'b0001, 39'h0006, 64'h0, 64'h7FFF_0000_0000_0000, 0, 0, 8'h00, 64'h0, 64'h0000_0000_0000_7FFF);
        vecs[11] = mk(4'b0011, 39'h0028, 64'h0, 64'h8000_0000_0000_0001, 0, 0, 8'h00, 64'h0, 64'h8000_0000_0000_0001);
        vecs[12] = mk(4'b0011, 39'h0004, 64'h0, 64'h0, 1, 0, 8'h00, 64'h0, 64'h0);
        vecs[13] = mk(4'b1100, 39'h0000, 64'h0, 64'h0, 2, 0, 8'h00, 64'h0, 64'h0);
        vecs[14] = mk(4'b1111, 39'h0000, 64'h0, 64'h0, 2, 0, 8'h00, 64'h0, 64'h0);
        vecs[15] = mk(4'b1101, 39'h0000, 64'h0, 64'h0, 2, 0, 8'h00, 64'h0, 64'h0);
        vecs[16] = mk(4'b0010, 39'h0002, 64'h0, 64'h0, 1, 0, 8'h00, 64'h0, 64'h0);
        vecs[17] = mk(4'b1010, 39'h0005, 64'h0, 64'h0, 1, 0, 8'h00, 64'h0, 64'h0);
        vecs[18] = mk(4'b0100, 39'h0005, 64'h0, 64'h0000_7F00_0000_0000, 0, 0, 8'h00, 64'h0, 64'h0000_0000_0000_007F);
        vecs[19] = mk(4'b0101, 39'h0002, 64'h0, 64'h0000_0000_FEDC_0000, 0, 0, 8'h00, 64'h0, 64'h0000_0000_0000_FEDC);
        vecs[20] = mk(4'b1000, 39'h0000, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 1, 8'h01, 64'h0000_0000_0000_00F0, 64'h0);
        vecs[21] = mk(4'b1110, 39'h0001, 64'h0, 64'h0, 2, 0, 8'h00, 64'h0, 64'h0);

        reset_i = 1'b1; pkt_v_i = 1'b0; pkt_opcode_i = 4'h0; pkt_addr_i = '0; pkt_data_i = '0;
        req_yumi_i = 1'b0; rdata_v_i = 1'b0; rdata_i = '0;
        repeat (3) tick();
        reset_i = 1'b0;

        // Reset state
        chk("rst_req_v", req_v_o, 1'b0);
        chk("rst_load_v", load_v_o, 1'b0);
        chk("rst_misaligned", misaligned_v_o, 1'b0);
        chk("rst_illegal", illegal_v_o, 1'b0);
        chk("rst_load_data", load_data_o, 64'h0);
        chk("rst_pkt_ready", pkt_ready_o, 1'b1);

        // Table-driven single transactions
        for (int i = 0; i < 22; i++) begin
            $display("vec %0d: op=%b addr=0x%h data=0x%h kind=%0d", i, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].kind);
            send(vecs[i].op, vecs[i].addr, vecs[i].data);
            chk("vec_pkt_ready", pkt_ready_o, 1'b1);
            tick();
            pkt_v_i = 1'b0;
            chk("vec_illegal_v", illegal_v_o, vecs[i].kind == 2);
            chk("vec_misaligned_v", misaligned_v_o, vecs[i].kind == 1);
            chk("vec_req_v", req_v_o, vecs[i].kind == 0);
            if (vecs[i].kind == 0) begin
                chk("vec_req_addr", req_addr_o, {vecs[i].addr[38:3], 3'b000});
                chk("vec_req_store", req_store_o, vecs[i].st);
                chk("vec_req_wmask", req_wmask_o, vecs[i].wmask);
                if (vecs[i].st) chk("vec_req_wdata", req_wdata_o, vecs[i].wdata);
                req_yumi_i = 1'b1;
                tick();
                req_yumi_i = 1'b0;
                chk("vec_req_v_popped", req_v_o, 1'b0);
                if (!vecs[i].st) begin
                    rdata_v_i = 1'b1; rdata_i = vecs[i].rdata;
                    tick();
                    rdata_v_i = 1'b0;
                    chk("vec_load_v", load_v_o, 1'b1);
                    chk("vec_load_data", load_data_o, vecs[i].ldata);
                end else begin
                    tick();
                    chk("vec_store_no_load_v", load_v_o, 1'b0);
                end
            end else begin
                tick();
                chk("vec_pulse_ill_gone", illegal_v_o, 1'b0);
                chk("vec_pulse_mis_gone", misaligned_v_o, 1'b0);
                chk("vec_err_no_req", req_v_o, 1'b0);
                chk("vec_err_ready", pkt_ready_o, 1'b1);
            end
            tick();
            chk("vec_load_v_idle", load_v_o, 1'b0);
        end

        // Sequence A: three back-to-back ld with yumi held low
        $display("seq A: fill to full, one dequeue, third ld accepted in order");
        send(4'b0011, 39'h100, 64'h0);
        chk("A_ready0", pkt_ready_o, 1'b1);
        tick();
        pkt_addr_i = 39'h108;
        chk("A_ready1", pkt_ready_o, 1'b1);
        tick();
        pkt_addr_i = 39'h110;
        chk("A_ready_full", pkt_ready_o, 1'b0);
        chk("A_head0", req_addr_o, 39'h100);
        tick();
        chk("A_still_full", pkt_ready_o, 1'b0);
        req_yumi_i = 1'b1; rdata_v_i = 1'b1; rdata_i = 64'hAAAA_0000_0000_0001;
        chk("A_no_same_cycle_free", pkt_ready_o, 1'b0);
        tick();
        req_yumi_i = 1'b0; rdata_v_i = 1'b0;
        chk("A_load_v0", load_v_o, 1'b1);
        chk("A_load_data0", load_data_o, 64'hAAAA_0000_0000_0001);
        chk("A_ready_back", pkt_ready_o, 1'b1);
        tick();
        pkt_v_i = 1'b0;
        chk("A_head1", req_addr_o, 39'h108);
        req_yumi_i = 1'b1; rdata_v_i = 1'b1; rdata_i = 64'hBBBB_0000_0000_0002;
        tick();
        chk("A_load_data1", load_data_o, 64'hBBBB_0000_0000_0002);
        chk("A_head2", req_addr_o, 39'h110);
        rdata_i = 64'hCCCC_0000_0000_0003;
        tick();
        req_yumi_i = 1'b0; rdata_v_i = 1'b0;
        chk("A_load_data2", load_data_o, 64'hCCCC_0000_0000_0003);
        chk("A_req_empty", req_v_o, 1'b0);
        tick();
        chk("A_load_v_idle", load_v_o, 1'b0);

        // Sequence B: lw 0x..4 then lhu 0x..2, results in order on consecutive cycles
        $display("seq B: lw then lhu, back-to-back responses");
        send(4'b0010, 39'h3004, 64'h0);
        tick();
        send(4'b0101, 39'h3002, 64'h0);
        tick();
        pkt_v_i = 1'b0;
        chk("B_head0", req_addr_o, 39'h3000);
        req_yumi_i = 1'b1;
        tick();
        chk("B_head1", req_addr_o, 39'h3000);
        tick();
        req_yumi_i = 1'b0;
        rdata_v_i = 1'b1; rdata_i = 64'h89AB_CDEF_0000_0000;
        tick();
        rdata_i = 64'h0000_0000_ABCD_0000;
        chk("B_load_v0", load_v_o, 1'b1);
        chk("B_load_data0", load_data_o, 64'hFFFF_FFFF_89AB_CDEF);
        tick();
        rdata_v_i = 1'b0;
        chk("B_load_v1", load_v_o, 1'b1);
        chk("B_load_data1", load_data_o, 64'h0000_0000_0000_ABCD);
        tick();
        chk("B_load_v_idle", load_v_o, 1'b0);

        // Sequence C: reset with two loads outstanding
        $display("seq C: reset with two loads outstanding");
        send(4'b0011, 39'h200, 64'h0);
        tick();
        pkt_addr_i = 39'h208;
        tick();
        pkt_v_i = 1'b0;
        chk("C_full", pkt_ready_o, 1'b0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("C_req_v", req_v_o, 1'b0);
        chk("C_load_v", load_v_o, 1'b0);
        chk("C_ready", pkt_ready_o, 1'b1);
        chk("C_load_data", load_data_o, 64'h0);
        tick();
        chk("C_req_v_later", req_v_o, 1'b0);
        chk("C_load_v_later", load_v_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_be_dcache_pkt_decoder.md
# bp_be_dcache_pkt_decoder

Dcache-side receiver for the MMU-to-dcache packet. It accepts packets carrying a dcache opcode, virtual address and store data, and decodes them into lane-aligned array requests with a byte write mask. It tracks outstanding loads in order and turns raw 64-bit array read data into sign- or zero-extended load results. It sits between the BE MMU and the dcache tag/data array stage.

## Interface
Parameters:
- vaddr_width_p, 39, virtual address width
- data_width_p, 64, data width; fixed at 64, with 8 byte lanes
- els_p, 2, depth of the request FIFO and of the load-tracking FIFO

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  synchronous, active-high reset
- pkt_v_i  in  1  packet valid
- pkt_opcode_i  in  4  bp_be_dcache_opcode_e
- pkt_addr_i  in  vaddr_width_p  byte address
- pkt_data_i  in  64  store data, right-justified
- pkt_ready_o  out  1  packet accepted when pkt_v_i & pkt_ready_o
- req_v_o  out  1  array request valid
- req_yumi_i  in  1  array consumes the request; only legal when req_v_o
- req_addr_o  out  vaddr_width_p  address with bits [2:0] cleared
- req_store_o  out  1  1 = store, 0 = load
- req_wmask_o  out  8  byte write mask; 0 for loads
- req_wdata_o  out  64  store data shifted into its lanes
- rdata_v_i  in  1  read data returning for the oldest outstanding load
- rdata_i  in  64  full 64-bit array word
- load_v_o  out  1  load result valid, one-cycle pulse
- load_data_o  out  64  extended load result
- misaligned_v_o  out  1  one-cycle pulse for a misaligned packet
- illegal_v_o  out  1  one-cycle pulse for an undefined opcode

## Operation
- Opcode decode:
  - opcode[3] = store
  - opcode[2] = unsigned
  - opcode[1:0] = log2(size in bytes)
- Illegal opcodes: 4'b0111, 4'b11xx, and any store with opcode[2]=1.
- Misaligned: addr[2:0] is not a multiple of the access size. Illegal is checked first.
- On acceptance of an illegal or misaligned packet:
  - Nothing is enqueued.
  - The matching pulse is registered and asserted the next cycle.
  - The two pulses are never high together.
- On acceptance of a legal, aligned packet:
  - Enqueue {addr, store, wmask, wdata} into the request FIFO.
  - For a load, also enqueue {size, unsigned, addr[2:0]} into the load-tracking FIFO.
- Write mask and data:
  - wmask = ((1<<(1<<size))-1) << addr[2:0]
  - wdata = pkt_data_i << (8*addr[2:0]), with bits above the access size masked to 0 before shifting.
- pkt_ready_o = request FIFO not full & load-tracking FIFO not full.
  - Computed from registered state only.
  - Does not depend on req_yumi_i or rdata_v_i; a same-cycle dequeue does not free a slot for that cycle.
- req_v_o = request FIFO not empty. The head is popped on req_yumi_i.
- Load response:
  - On rdata_v_i, pop the load-tracking head.
  - Compute rdata_i >> (8*offset), truncate to the access size, then sign- or zero-extend to 64 bits.
  - Register the result onto load_data_o.
  - ld ignores the unsigned bit.
- rdata_v_i while the tracking FIFO is empty is a protocol violation: it is ignored and flagged by a simulation assertion.
- Stores produce no load response.

## Timing
- Packet accepted in cycle N: req_v_o no earlier than N+1.
- Illegal or misaligned packet accepted in cycle N: the pulse is in N+1.
- rdata_v_i in cycle M: load_v_o=1 with valid data in M+1.
  - Back-to-back rdata_v_i gives back-to-back load_v_o.
- Simultaneous enqueue and dequeue on a non-full, non-empty FIFO: both occur and occupancy is unchanged.
- Reset state:
  - Both FIFOs are empty.
  - req_v_o=0, load_v_o=0, misaligned_v_o=0, illegal_v_o=0, load_data_o=0.
  - pkt_ready_o=1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight requests and tracked loads are discarded with no pulse.

## Structure
- Add to the dcache package:
  - struct bp_be_dcache_decode_s {store, unsigned, size[1:0]}
  - load-tracking entry struct {decode, offset[2:0]}
  - localparam dword_width_gp = 64
- Both queues are instances of bsg_fifo_1r1w_small (els_p, ready-then-valid input).
- Decode and extraction are combinational logic inside this module.

## Test plan
- lb at addr 0x...3, rdata byte3=0x80 → load_data_o=0xFFFF_FFFF_FFFF_FF80 one cycle after rdata_v_i. The same sequence with lbu → 0x0000_0000_0000_0080.
- sw at addr 0x...4, data 0xDEAD_1122_3344 → req_wmask_o=0xF0, req_wdata_o=0x1122_3344_0000_0000, req_store_o=1, and no load_v_o.
- lh at 0x...1 → misaligned_v_o pulse next cycle, no req_v_o, and FIFO occupancy unchanged. Opcode 4'b0111 → illegal_v_o pulse only.
- Three back-to-back ld packets with req_yumi_i held at 0 → two are accepted, then pkt_ready_o=0. One yumi → ready returns the next cycle, and the third is accepted in order.
- Two loads lw 0x...4 and lhu 0x...2 → results return in order, extended correctly, on consecutive cycles.
- reset_i asserted with two loads outstanding → req_v_o=0, no load_v_o, and pkt_ready_o=1 after reset.
